// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory request in flight,
// buffers one returned instruction and feeds the IF/ID register with redirect handling.
package instruction_fetch_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] instr;
  } if_id_inf_t;
endpackage

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output if_id_inf_t      if_id_inf
);

  localparam if_id_inf_t BUBBLE = '{pc: '0, pc_inc: '0, instr: NOP_INSTR};
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;
  if_id_inf_t      hb, hb_n;
  if_id_inf_t      if_id_n;
  logic            hb_valid, hb_valid_n;
  logic            discard, discard_n;
  logic            req_fire;
  logic [XLEN-1:0] redirect_target;

  // A new request is only useful if the holding buffer can drain; gated off during reset.
  assign imem_req_valid  = rst && (state == S_REQ) && (!hb_valid || !stall);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // Next-state, buffer and IF/ID register update; redirect is applied last so it wins.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    hb_n       = hb;
    hb_valid_n = hb_valid;
    discard_n  = discard;
    if_id_n    = if_id_inf;

    if (!stall) begin
      if_id_n    = hb_valid ? hb : BUBBLE;
      hb_valid_n = 1'b0;
    end

    case (state)
      S_REQ: begin
        if (req_fire) begin
          req_pc_n = fetch_pc;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_n = S_REQ;
          if (discard) begin
            discard_n = 1'b0;
          end else begin
            hb_n       = '{pc: req_pc, pc_inc: req_pc + PC_STEP, instr: imem_rsp_data};
            hb_valid_n = 1'b1;
            fetch_pc_n = req_pc + PC_STEP;
          end
        end
      end
      default: state_n = S_REQ;
    endcase

    // Exactly one stale response may be outstanding; discard tracks it.
    if (redirect) begin
      fetch_pc_n = redirect_target;
      hb_valid_n = 1'b0;
      if_id_n    = BUBBLE;
      if (state == S_WAIT) begin
        if (imem_rsp_valid) begin
          state_n   = S_REQ;
          discard_n = 1'b0;
        end else begin
          state_n   = S_WAIT;
          discard_n = 1'b1;
        end
      end else if (req_fire) begin
        state_n   = S_WAIT;
        discard_n = 1'b1;
      end else begin
        state_n = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      hb        <= BUBBLE;
      hb_valid  <= 1'b0;
      discard   <= 1'b0;
      if_id_inf <= BUBBLE;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      req_pc    <= req_pc_n;
      hb        <= hb_n;
      hb_valid  <= hb_valid_n;
      discard   <= discard_n;
      if_id_inf <= if_id_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed per-cycle vector bench for instruction_fetch with a hand-traced expected
// request/IF-ID sequence covering stalls, back-pressure, redirects, wrap and reset.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  if_id_inf_t  if_id_inf;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_inf      (if_id_inf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rs;     // rst level for the cycle
    bit          st;     // stall
    bit          rd;     // redirect
    logic [31:0] rpc;
    bit          rdy;
    bit          rsp;
    bit          ev;     // expected req_valid before the edge
    logic [31:0] ea;     // expected req_addr before the edge
    bit          en;     // expect bubble after the edge
    logic [31:0] ep;     // expected pc after the edge
  } row_t;

  row_t rows[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic add(input bit rs, input bit st, input bit rd, input logic [31:0] rpc,
                     input bit rdy, input bit rsp, input bit ev, input logic [31:0] ea,
                     input bit en, input logic [31:0] ep);
    row_t r;
    r = '{rs: rs, st: st, rd: rd, rpc: rpc, rdy: rdy, rsp: rsp, ev: ev, ea: ea, en: en, ep: ep};
    rows.push_back(r);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx, input bit en, input logic [31:0] ep);
    check({tag, ".pc"}, idx, if_id_inf.pc, en ? 32'h0 : ep);
    check({tag, ".pc_inc"}, idx, if_id_inf.pc_inc, en ? 32'h0 : ep + 32'd4);
    check({tag, ".instr"}, idx, if_id_inf.instr, en ? NOP : mem_word(ep));
  endtask

  initial begin
    logic [31:0] last_acc;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    last_acc = '0;

    //  rs st rd rpc            rdy rsp  ev ea             en ep
    add(0, 0, 0, 32'h0,         1,  0,   0, 32'h100,       1, 0);
    // start-up: 1-cycle memory
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h104,       0, 32'h100);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h104,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h108,       0, 32'h104);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h108,       1, 0);
    // back-pressure: ready low 5 cycles
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h10C,       0, 32'h108);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 32'h0, 0, 0, 1, 32'h10C, 1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h10C,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h10C,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h110,       0, 32'h10C);
    // stall 4 cycles while 0x110 returns
    add(1, 1, 0, 32'h0,         1,  1,   0, 32'h110,       0, 32'h10C);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 32'h0, 1, 0, 0, 32'h114, 0, 32'h10C);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h114,       0, 32'h110);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h114,       1, 0);
    // redirect while waiting, stale response dropped
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h118,       0, 32'h114);
    add(1, 0, 1, 32'h200,       1,  0,   0, 32'h118,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h204,       0, 32'h200);
    // unaligned redirect coincident with handshake
    add(1, 0, 1, 32'h203,       1,  0,   1, 32'h204,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h200,       1, 0);
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h204,       0, 32'h200);
    // redirect before handshake, then redirect coincident with response
    add(1, 0, 1, 32'h250,       0,  0,   1, 32'h204,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h250,       1, 0);
    add(1, 0, 1, 32'h300,       1,  1,   0, 32'h250,       1, 0);
    add(1, 0, 1, 32'h400,       0,  0,   1, 32'h300,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h400,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h400,       1, 0);
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h404,       0, 32'h400);
    // back-to-back redirects while a stale response is outstanding
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h404,       1, 0);
    add(1, 0, 1, 32'h500,       1,  0,   0, 32'h404,       1, 0);
    add(1, 0, 1, 32'h600,       1,  0,   0, 32'h500,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h600,       1, 0);
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h600,       1, 0);
    // address wrap
    add(1, 0, 1, 32'hFFFF_FFFC, 0,  0,   1, 32'h600,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'hFFFF_FFFC, 1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'hFFFF_FFFC, 1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h0,         0, 32'hFFFF_FFFC);
    // reset mid-wait, then a stray response is ignored
    add(0, 0, 0, 32'h0,         1,  0,   0, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         0,  1,   1, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         1,  0,   1, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         1,  1,   0, 32'h100,       1, 0);
    add(1, 0, 0, 32'h0,         0,  0,   1, 32'h104,       0, 32'h100);

    @(negedge clk);
    foreach (rows[i]) begin
      rst            = rows[i].rs;
      stall          = rows[i].st;
      redirect       = rows[i].rd;
      redirect_pc    = rows[i].rpc;
      imem_req_ready = rows[i].rdy;
      imem_rsp_valid = rows[i].rsp;
      imem_rsp_data  = mem_word(last_acc);
      #1;
      check("req_valid", i, 32'(imem_req_valid), 32'(rows[i].ev));
      check("req_addr", i, imem_req_addr, rows[i].ea);
      if (!rows[i].rs) check_out("rst_async", i, 1'b1, 32'h0);
      if (rows[i].ev && rows[i].rdy && rows[i].rs) last_acc = rows[i].ea;
      @(posedge clk);
      #1;
      check_out("if_id", i, rows[i].en, rows[i].ep);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
